i2c_slave_regfile: RTL and testbench

//  Synthesizable I2C slave (responder end of the bus driven by i2c_master_top). Owns a byte register file

---
 rtl/i2c_slave_pkg.sv | 27 ++
 rtl/i2c_slave_filt.sv | 55 +++++
 rtl/i2c_slave_regfile.sv | 215 +++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_pkg.sv
// Shared types for the I2C register-file slave: FSM state encoding and default parameters.
// Latency: none (declarations only); backpressure: n/a.
package i2c_slave_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        WAIT_STOP
    } state_t;

    localparam logic [6:0] DEF_SADR = 7'b001_0000;
    localparam int         DEF_AW   = 4;
    localparam int         DEF_FILT = 3;

    // States where the slave shifts in a byte on each SCL rise.
    function automatic logic is_rx_state(input state_t s);
        return (s == ADDR) || (s == PTR) || (s == WRITE);
    endfunction

endpackage

// File: rtl/i2c_slave_filt.sv
// SCL/SDA conditioner: 2-FF sync, FILT-deep equality filter, edge and START/STOP strobes.
// Latency: FILT+3 clk pin-to-strobe; backpressure: none, strobes are single-cycle.
module i2c_slave_filt #(
    parameter int FILT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_raw,
    input  logic sda_raw,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0]      scl_sync;
    logic [1:0]      sda_sync;
    logic [FILT-1:0] scl_hist;
    logic [FILT-1:0] sda_hist;
    logic            scl;
    logic            scl_d;
    logic            sda_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= '1;
            sda_hist <= '1;
            scl      <= 1'b1;
            sda      <= 1'b1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_raw};
            sda_sync <= {sda_sync[0], sda_raw};
            scl_hist <= FILT'({scl_hist, scl_sync[1]});
            sda_hist <= FILT'({sda_hist, sda_sync[1]});
            // Level only moves once the whole history agrees; shorter pulses are dropped.
            if (&scl_hist)       scl <= 1'b1;
            else if (~|scl_hist) scl <= 1'b0;
            if (&sda_hist)       sda <= 1'b1;
            else if (~|sda_hist) sda <= 1'b0;
            scl_d <= scl;
            sda_d <= sda;
        end
    end

    assign scl_rise  = scl & ~scl_d;
    assign scl_fall  = ~scl & scl_d;
    assign start_det = scl & scl_d & sda_d & ~sda;
    assign stop_det  = scl & scl_d & ~sda_d & sda;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave owning a 2**AW byte register file behind an auto-incrementing sub-address pointer.
// Latency: SDA drive 1 clk after filtered SCL fall; backpressure: none, never stretches SCL.
module i2c_slave_regfile
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0] SADR = DEF_SADR,
    parameter int         AW   = DEF_AW,
    parameter int         FILT = DEF_FILT
) (
    input  logic          wb_clk_i,
    input  logic          arst_i,
    input  logic          scl_pad_i,
    output logic          scl_pad_o,
    output logic          scl_padoen_o,
    input  logic          sda_pad_i,
    output logic          sda_pad_o,
    output logic          sda_padoen_o,
    input  logic [AW-1:0] host_addr_i,
    output logic [7:0]    host_data_o,
    output logic          wr_stb_o,
    output logic [AW-1:0] wr_addr_o,
    output logic          busy_o
);

    localparam int DEPTH = 1 << AW;

    logic          sda;
    logic          scl_rise;
    logic          scl_fall;
    logic          start_det;
    logic          stop_det;

    state_t        state_q,   state_d;
    logic [2:0]    bit_q,     bit_d;
    logic [7:0]    sr_q,      sr_d;
    logic [AW-1:0] ptr_q,     ptr_d;
    logic          rw_q,      rw_d;
    logic          ack_ph_q,  ack_ph_d;
    logic          sda_low_q, sda_low_d;
    logic          busy_q,    busy_d;
    logic          wr_stb_q,  wr_stb_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic          rf_we;
    logic [7:0]    byte_in;
    logic [7:0]    rf [DEPTH];

    i2c_slave_filt #(.FILT(FILT)) u_filt (
        .clk       (wb_clk_i),
        .rst_n     (arst_i),
        .scl_raw   (scl_pad_i),
        .sda_raw   (sda_pad_i),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign byte_in = {sr_q[6:0], sda};

    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_q   <= IDLE;
            bit_q     <= '0;
            sr_q      <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            ack_ph_q  <= 1'b0;
            sda_low_q <= 1'b0;
            busy_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            for (int i = 0; i < DEPTH; i++) rf[i] <= 8'h00;
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            sr_q      <= sr_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            ack_ph_q  <= ack_ph_d;
            sda_low_q <= sda_low_d;
            busy_q    <= busy_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            if (rf_we) rf[ptr_q] <= byte_in;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        sr_d      = sr_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        ack_ph_d  = ack_ph_q;
        sda_low_d = sda_low_q;
        busy_d    = busy_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        rf_we     = 1'b0;

        // Bus conditions pre-empt any SCL edge seen in the same cycle.
        if (start_det) begin
            state_d   = ADDR;
            bit_d     = '0;
            sda_low_d = 1'b0;
        end else if (stop_det) begin
            state_d   = IDLE;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WRITE: begin
                    if (scl_rise && is_rx_state(state_q)) begin
                        sr_d  = byte_in;
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            ack_ph_d = 1'b0;
                            case (state_q)
                                ADDR: begin
                                    if (byte_in[7:1] == SADR) begin
                                        state_d = ADDR_ACK;
                                        rw_d    = byte_in[0];
                                        busy_d  = 1'b1;
                                    end else begin
                                        state_d = IDLE;
                                        busy_d  = 1'b0;
                                    end
                                end
                                PTR: begin
                                    ptr_d   = byte_in[AW-1:0];
                                    state_d = PTR_ACK;
                                end
                                default: begin
                                    rf_we     = 1'b1;
                                    wr_stb_d  = 1'b1;
                                    wr_addr_d = ptr_q;
                                    ptr_d     = ptr_q + AW'(1);
                                    state_d   = WRITE_ACK;
                                end
                            endcase
                        end
                    end
                end

                ADDR_ACK, PTR_ACK, WRITE_ACK: begin
                    if (scl_rise) begin
                        ack_ph_d = 1'b1;
                    end else if (scl_fall) begin
                        if (!ack_ph_q) begin
                            sda_low_d = 1'b1;
                        end else begin
                            sda_low_d = 1'b0;
                            bit_d     = '0;
                            if (state_q == ADDR_ACK && rw_q) begin
                                sr_d      = rf[ptr_q];
                                sda_low_d = ~rf[ptr_q][7];
                                state_d   = READ;
                            end else if (state_q == ADDR_ACK) begin
                                state_d = PTR;
                            end else begin
                                state_d = WRITE;
                            end
                        end
                    end
                end

                READ: begin
                    if (scl_rise) begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            ptr_d    = ptr_q + AW'(1);
                            ack_ph_d = 1'b0;
                            state_d  = READ_ACK;
                        end
                    end else if (scl_fall) begin
                        sr_d      = {sr_q[6:0], sr_q[7]};
                        sda_low_d = ~sr_q[6];
                    end
                end

                READ_ACK: begin
                    if (scl_fall && !ack_ph_q) begin
                        sda_low_d = 1'b0;
                    end else if (scl_rise) begin
                        // Master NACK ends the read burst; only START/STOP follow.
                        if (sda) begin
                            state_d = WAIT_STOP;
                            busy_d  = 1'b0;
                        end else begin
                            ack_ph_d = 1'b1;
                        end
                    end else if (scl_fall) begin
                        sr_d      = rf[ptr_q];
                        sda_low_d = ~rf[ptr_q][7];
                        bit_d     = '0;
                        state_d   = READ;
                    end
                end

                default: ;
            endcase
        end
    end

    assign scl_pad_o    = 1'b0;
    assign scl_padoen_o = 1'b1;
    assign sda_pad_o    = 1'b0;
    assign sda_padoen_o = ~sda_low_q;
    assign host_data_o  = rf[host_addr_i];
    assign wr_stb_o     = wr_stb_q;
    assign wr_addr_o    = wr_addr_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench: bit-banged open-drain I2C master against i2c_slave_regfile with scoreboard queues.
module tb_i2c_slave_regfile;
    localparam int Q = 25;

    logic       clk = 1'b0;
    logic       arst_i;
    logic       m_scl, m_sda, glitch;
    logic       scl_bus, sda_bus;
    logic       scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o;
    logic [3:0] host_addr_i;
    logic [7:0] host_data_o;
    logic       wr_stb_o;
    logic [3:0] wr_addr_o;
    logic       busy_o;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] wr_q[$];
    logic [7:0] rd_q[$];
    logic       watch_rel = 1'b0;
    logic       drove = 1'b0;
    logic       ack;

    always #5 clk = ~clk;

    assign scl_bus = m_scl & (scl_padoen_o | scl_pad_o);
    assign sda_bus = m_sda & ~glitch & (sda_padoen_o | sda_pad_o);

    i2c_slave_regfile dut (
        .wb_clk_i     (clk),
        .arst_i       (arst_i),
        .scl_pad_i    (scl_bus),
        .scl_pad_o    (scl_pad_o),
        .scl_padoen_o (scl_padoen_o),
        .sda_pad_i    (sda_bus),
        .sda_pad_o    (sda_pad_o),
        .sda_padoen_o (sda_padoen_o),
        .host_addr_i  (host_addr_i),
        .host_data_o  (host_data_o),
        .wr_stb_o     (wr_stb_o),
        .wr_addr_o    (wr_addr_o),
        .busy_o       (busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(posedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b1; wait_q();
    endtask

    task automatic i2c_write(input logic [7:0] d, input int stretch_bit, output logic ak);
        for (int i = 7; i >= 0; i--) begin
            m_sda = d[i];
            if (7 - i == stretch_bit) repeat (10000) @(posedge clk);
            wait_q();
            m_scl = 1'b1; wait_q(); wait_q();
            m_scl = 1'b0; wait_q();
        end
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        @(negedge clk);
        ak = ~sda_bus;
        wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic i2c_read(input logic mack, input string tag);
        logic [7:0] d;
        logic [7:0] e;
        for (int i = 7; i >= 0; i--) begin
            m_sda = 1'b1; wait_q();
            m_scl = 1'b1; wait_q();
            @(negedge clk);
            d[i] = sda_bus;
            wait_q();
            m_scl = 1'b0; wait_q();
        end
        m_sda = ~mack; wait_q();
        m_scl = 1'b1; wait_q(); wait_q();
        m_scl = 1'b0; wait_q();
        m_sda = 1'b1;
        e = (rd_q.size() != 0) ? rd_q.pop_front() : 8'hxx;
        chk(tag, {24'h0, d}, {24'h0, e});
    endtask

    task automatic host_chk(input logic [3:0] a, input string tag, input logic [7:0] e);
        @(negedge clk);
        host_addr_i = a;
        #1;
        chk(tag, {24'h0, host_data_o}, {24'h0, e});
    endtask

    always @(negedge clk) begin
        if (arst_i === 1'b1 && wr_stb_o === 1'b1) begin
            logic [3:0] e;
            e = (wr_q.size() != 0) ? wr_q.pop_front() : 4'bxxxx;
            chk("wr_addr", {28'h0, wr_addr_o}, {28'h0, e});
        end
        if (watch_rel && sda_padoen_o !== 1'b1) drove <= 1'b1;
    end

    initial begin
        arst_i = 1'b0; m_scl = 1'b1; m_sda = 1'b1; glitch = 1'b0; host_addr_i = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_sda_oe", {31'h0, sda_padoen_o}, 32'h1);
        chk("rst_busy",   {31'h0, busy_o},       32'h0);
        chk("rst_wr_stb", {31'h0, wr_stb_o},     32'h0);
        chk("rst_scl_oe", {31'h0, scl_padoen_o}, 32'h1);
        arst_i = 1'b1;
        wait_q();
        host_chk(4'd1, "rst_reg1", 8'h00);

        // 1: write A5,5A from ptr 1
        i2c_start();
        i2c_write(8'h20, -1, ack); chk("w_addr_ack", {31'h0, ack}, 32'h1);
        @(negedge clk);
        chk("w_busy", {31'h0, busy_o}, 32'h1);
        i2c_write(8'h01, -1, ack); chk("w_ptr_ack", {31'h0, ack}, 32'h1);
        wr_q.push_back(4'd1);
        i2c_write(8'hA5, -1, ack); chk("w_d0_ack", {31'h0, ack}, 32'h1);
        wr_q.push_back(4'd2);
        i2c_write(8'h5A, -1, ack); chk("w_d1_ack", {31'h0, ack}, 32'h1);
        i2c_stop();
        chk("w_strobes", wr_q.size(), 32'h0);
        chk("w_idle_busy", {31'h0, busy_o}, 32'h0);
        host_chk(4'd1, "w_reg1", 8'hA5);
        host_chk(4'd2, "w_reg2", 8'h5A);

        // 2: pointer write, repeated START, read two bytes
        i2c_start();
        i2c_write(8'h20, -1, ack); chk("r_addr_ack", {31'h0, ack}, 32'h1);
        i2c_write(8'h01, -1, ack); chk("r_ptr_ack", {31'h0, ack}, 32'h1);
        i2c_start();
        i2c_write(8'h21, -1, ack); chk("r_addrr_ack", {31'h0, ack}, 32'h1);
        rd_q.push_back(8'hA5); i2c_read(1'b1, "r_byte0");
        rd_q.push_back(8'h5A); i2c_read(1'b0, "r_byte1");
        @(negedge clk);
        chk("r_nack_busy", {31'h0, busy_o}, 32'h0);
        chk("r_nack_rel", {31'h0, sda_padoen_o}, 32'h1);
        i2c_stop();

        // 3: wrong address stays off the bus
        watch_rel = 1'b1;
        i2c_start();
        i2c_write(8'h22, -1, ack); chk("bad_addr_nack", {31'h0, ack}, 32'h0);
        i2c_write(8'h77, -1, ack); chk("bad_data_nack", {31'h0, ack}, 32'h0);
        i2c_stop();
        watch_rel = 1'b0;
        chk("bad_never_drove", {31'h0, drove}, 32'h0);
        chk("bad_busy", {31'h0, busy_o}, 32'h0);
        host_chk(4'd1, "bad_reg1", 8'hA5);

        // 4: pointer wrap on write and read
        i2c_start();
        i2c_write(8'h20, -1, ack);
        i2c_write(8'h0F, -1, ack);
        wr_q.push_back(4'd15);
        i2c_write(8'h11, -1, ack);
        wr_q.push_back(4'd0);
        i2c_write(8'h22, -1, ack); chk("wrap_ack", {31'h0, ack}, 32'h1);
        i2c_stop();
        host_chk(4'd15, "wrap_reg15", 8'h11);
        host_chk(4'd0,  "wrap_reg0",  8'h22);
        i2c_start();
        i2c_write(8'h20, -1, ack);
        i2c_write(8'h0F, -1, ack);
        i2c_start();
        i2c_write(8'h21, -1, ack);
        rd_q.push_back(8'h11); i2c_read(1'b1, "wrap_rd0");
        rd_q.push_back(8'h22); i2c_read(1'b0, "wrap_rd1");
        i2c_stop();

        // 5: master holds SCL low mid data byte
        i2c_start();
        i2c_write(8'h20, -1, ack);
        i2c_write(8'h05, -1, ack);
        wr_q.push_back(4'd5);
        i2c_write(8'h3C, 4, ack); chk("stretch_ack", {31'h0, ack}, 32'h1);
        i2c_stop();
        chk("stretch_strobes", wr_q.size(), 32'h0);
        host_chk(4'd5, "stretch_reg5", 8'h3C);

        // 6: reset while slave drives a 0 data bit, then a 1-clk SDA glitch
        i2c_start();
        i2c_write(8'h20, -1, ack);
        i2c_write(8'h06, -1, ack);
        i2c_start();
        i2c_write(8'h21, -1, ack);
        @(negedge clk);
        chk("rd_driving", {31'h0, sda_padoen_o}, 32'h0);
        arst_i = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_rel",  {31'h0, sda_padoen_o}, 32'h1);
        chk("rst_mid_busy", {31'h0, busy_o},       32'h0);
        host_chk(4'd1, "rst_mid_clr", 8'h00);
        @(negedge clk);
        arst_i = 1'b1;
        i2c_stop();
        wait_q();
        @(negedge clk); glitch = 1'b1;
        @(negedge clk); glitch = 1'b0;
        wait_q();
        m_scl = 1'b0; wait_q();
        i2c_write(8'h20, -1, ack); chk("glitch_nack", {31'h0, ack}, 32'h0);
        chk("glitch_busy", {31'h0, busy_o}, 32'h0);
        i2c_stop();
        chk("end_wr_q", wr_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
